// File: rtl/sca_pkg.sv
// Shared state encodings and default widths for the signed comparator arbiter.
// Imported by signed_cmp_arbiter and its round-robin picker.
package sca_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMP  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int CMP_WIDTH = 4;
   localparam int CMP_ID_W  = 2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CMP  = ST_CMP,
      S_RESP = ST_RESP
   } sca_state_e;

endpackage

// File: rtl/signed_cmp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above i_ptr with wrap.
// Zero latency; no flow control of its own.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      // Scan from farthest to nearest so the request closest to i_ptr overwrites the rest.
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N]) begin
            o_any = 1'b1;
            o_idx = IDX_W'((int'(i_ptr) + k) % N);
         end
      end
      if (o_any) o_gnt[o_idx] = 1'b1;
   end

endmodule

// File: rtl/signed_cmp_arbiter.sv
// Round-robin arbiter sharing one signed less-than comparator; SCA_EQ_OUT_EN adds a registered resp_eq.
// resp_valid two cycles after the grant cycle, >=3 cycles/txn; result held until resp_ready, no grants while busy.
module signed_cmp_arbiter
   import sca_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = CMP_WIDTH,
   parameter int ID_W  = CMP_ID_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic                   resp_lt
`ifdef SCA_EQ_OUT_EN
   ,
   output logic                   resp_eq
`endif
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   sca_state_e       r_state;
   sca_state_e       w_state_nxt;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  r_resp_id;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_lt;
   logic [N_REQ-1:0] w_gnt;
   logic [ID_W-1:0]  w_idx;
   logic             w_any;
   logic             w_accept;
   logic [WIDTH:0]   w_diff;
`ifdef SCA_EQ_OUT_EN
   logic             r_eq;
`endif

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign req_ready  = (r_state == S_IDLE && !reset) ? w_gnt : '0;
   assign w_accept   = w_any && (r_state == S_IDLE) && !reset;
   // One extra sign bit makes the subtraction overflow-free, so its MSB is the signed less-than.
   assign w_diff     = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
   assign resp_valid = (r_state == S_RESP);
   assign resp_id    = r_resp_id;
   assign resp_lt    = r_lt;
`ifdef SCA_EQ_OUT_EN
   assign resp_eq    = r_eq;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_CMP;
         S_CMP:   w_state_nxt = S_RESP;
         S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr     <= '0;
         r_id      <= '0;
         r_resp_id <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_lt      <= 1'b0;
`ifdef SCA_EQ_OUT_EN
         r_eq      <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_a  <= req_a[w_idx*WIDTH +: WIDTH];
            r_b  <= req_b[w_idx*WIDTH +: WIDTH];
            r_id <= w_idx;
         end
         if (r_state == S_CMP) begin
            r_lt      <= w_diff[WIDTH];
            r_resp_id <= r_id;
`ifdef SCA_EQ_OUT_EN
            r_eq      <= (r_a == r_b);
`endif
         end
         // The requester just served drops to lowest priority.
         if (r_state == S_RESP && resp_ready)
            r_ptr <= (r_resp_id == LAST_ID) ? '0 : r_resp_id + 1'b1;
      end
   end

endmodule

// File: tb/tb_signed_cmp_arbiter.sv
// Randomized self-checking bench for signed_cmp_arbiter against a round-robin / signed-compare reference model.
module tb_signed_cmp_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic        resp_lt;
`ifdef SCA_EQ_OUT_EN
   logic        resp_eq;
`endif

   int n_chk   = 0;
   int n_err   = 0;
   int exp_ptr = 0;

   always #5 clk = ~clk;

   signed_cmp_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_lt    (resp_lt)
`ifdef SCA_EQ_OUT_EN
      ,
      .resp_eq    (resp_eq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic int to_int(input logic [3:0] x);
      return x[3] ? int'(x) - 16 : int'(x);
   endfunction

   function automatic logic ref_lt(input logic [3:0] a, input logic [3:0] b);
      return to_int(a) < to_int(b);
   endfunction

   // Entered at posedge+1 with the DUT idle; leaves at posedge+1 right after the response handshake.
   task automatic run_txn(input logic [3:0] vld, input logic [3:0] pa, input logic [3:0] pb,
                          input logic [3:0] cmp_vld, input logic [3:0] rest_vld, input int hold,
                          output logic [1:0] got_id);
      int          w;
      logic [15:0] va;
      logic [15:0] vb;
      w  = pick(vld, exp_ptr);
      va = 16'($urandom);
      vb = 16'($urandom);
      va[w*4 +: 4] = pa;
      vb[w*4 +: 4] = pb;
      req_valid  = vld;
      req_a      = va;
      req_b      = vb;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("grant", 32'(req_ready), 32'(1 << w));
      chk("idle_resp_vld", 32'(resp_valid), 0);
      @(posedge clk); #1;
      req_valid = cmp_vld;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      @(negedge clk);
      chk("cmp_rdy", 32'(req_ready), 0);
      chk("cmp_resp_vld", 32'(resp_valid), 0);
      @(posedge clk); #1;
      req_valid = rest_vld;
      @(negedge clk);
      chk("resp_vld", 32'(resp_valid), 1);
      chk("resp_id", 32'(resp_id), 32'(w));
      chk("resp_lt", 32'(resp_lt), 32'(ref_lt(pa, pb)));
`ifdef SCA_EQ_OUT_EN
      chk("resp_eq", 32'(resp_eq), 32'(pa == pb));
`endif
      chk("resp_rdy", 32'(req_ready), 0);
      got_id = resp_id;
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_vld", 32'(resp_valid), 1);
         chk("hold_id", 32'(resp_id), 32'(w));
         chk("hold_lt", 32'(resp_lt), 32'(ref_lt(pa, pb)));
         chk("hold_rdy", 32'(req_ready), 0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 4'b0;
      exp_ptr    = (w + 1) % 4;
   endtask

   task automatic idle_chk(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_resp_vld", 32'(resp_valid), 0);
         chk("idle_rdy", 32'(req_ready), 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      req_valid  = 4'hF;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_resp_vld", 32'(resp_valid), 0);
      chk("rst_id", 32'(resp_id), 0);
      chk("rst_lt", 32'(resp_lt), 0);
`ifdef SCA_EQ_OUT_EN
      chk("rst_eq", 32'(resp_eq), 0);
`endif
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 4'b0;
      exp_ptr   = 0;
   endtask

   logic [1:0] gid;
   logic [1:0] fair_ord [6];

   initial begin
      fair_ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();

      run_txn(4'b0001, 4'b0001, 4'b0101, 4'b0, 4'b0, 0, gid);
      chk("single_id", 32'(gid), 0);

      run_txn(4'($urandom_range(1, 15)), 4'b1000, 4'b0111, 4'b0, 4'b0, 0, gid);
      run_txn(4'($urandom_range(1, 15)), 4'b0111, 4'b1000, 4'b0, 4'b0, 0, gid);
      run_txn(4'($urandom_range(1, 15)), 4'b1111, 4'b1111, 4'b0, 4'b0, 0, gid);
      run_txn(4'($urandom_range(1, 15)), 4'b1111, 4'b0000, 4'b0, 4'b0, 0, gid);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_txn(4'($urandom_range(1, 15)), 4'(a), 4'(b), 4'($urandom), 4'($urandom),
                    $urandom_range(0, 2), gid);

      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_txn(4'hF, 4'($urandom), 4'($urandom), 4'hF, 4'hF, 0, gid);
         chk("fair_order", 32'(gid), 32'(fair_ord[i]));
      end

      run_txn(4'b0010, 4'($urandom), 4'($urandom), 4'b0, 4'b0, 5, gid);
      idle_chk(1);

      // Reset during CMP with ptr at 2; the in-flight request must vanish.
      req_valid = 4'b1000;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      @(negedge clk);
      chk("midrst_grant", 32'(req_ready), 32'(4'b1000));
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = 4'hF;
      @(negedge clk);
      chk("midrst_rdy", 32'(req_ready), 0);
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 4'b0;
      exp_ptr   = 0;
      @(negedge clk);
      chk("midrst_resp_vld", 32'(resp_valid), 0);
      chk("midrst_id", 32'(resp_id), 0);
      chk("midrst_lt", 32'(resp_lt), 0);
      @(posedge clk); #1;
      idle_chk(3);
      run_txn(4'b1010, 4'($urandom), 4'($urandom), 4'b0, 4'b0, 0, gid);
      chk("midrst_ptr", 32'(gid), 1);
      run_txn(4'b0100, 4'($urandom), 4'($urandom), 4'b0, 4'b0, 0, gid);
      chk("midrst_req2", 32'(gid), 2);

      run_txn(4'b0001, 4'($urandom), 4'($urandom), 4'b0010, 4'b0, 1, gid);
      chk("drop_id", 32'(gid), 0);
      idle_chk(4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
